// File: rtl/pulse_train_generator.sv
// Synthetic pulse source: periodic pulse train with programmable epoch, period,
// width, count and LFSR-driven period jitter, plus ground-truth edge timing.
module pulse_train_generator #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PW_W      = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] epoch,
  input  logic [PW_W-1:0]  pulse_width,
  input  logic [PW_W-1:0]  num_pulses,
  input  logic [7:0]       jitter_mask,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [PW_W-1:0]  pulse_count,
  output logic [CNT_W-1:0] phase_cnt
);

  // One extra bit so P - W + jit never wraps.
  localparam int unsigned TW = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EPOCH,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [PW_W-1:0]  width_q, width_d;
  logic [PW_W-1:0]  npulses_q, npulses_d;
  logic [7:0]       jmask_q, jmask_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             cfg_err_q, cfg_err_d;
  logic [PW_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             pulse_out_q, pulse_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rise_c;
  logic [15:0]      lfsr_next_c;
  logic [TW-1:0]    jit_c;
  logic [TW-1:0]    low_len_c;
  logic             cfg_bad_c;

  assign pulse_out   = pulse_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign pulse_count = count_q;
  assign phase_cnt   = phase_q;

  // Fibonacci LFSR, taps 16/14/13/11, shifting left.
  assign lfsr_next_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign cfg_bad_c = (period == '0) || (pulse_width == '0) ||
                     (TW'(pulse_width) >= TW'(period));

  // Outputs trail the state by one edge, so the first HIGH cycle is the rising edge.
  assign rise_c = (state_q == S_HIGH) && (cnt_q == TW'(width_q) - TW'(1)) && !stop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    width_d     = width_q;
    npulses_d   = npulses_q;
    jmask_d     = jmask_q;
    lfsr_d      = lfsr_q;
    cfg_err_d   = cfg_err_q;
    count_d     = count_q;
    phase_d     = phase_q;
    pulse_out_d = (state_q == S_HIGH) && !stop;
    busy_d      = (state_q != S_IDLE) && !stop;
    done_d      = (state_q == S_DONE) && !stop;

    if (rise_c) begin
      lfsr_d  = lfsr_next_c;
      count_d = (count_q == '1) ? count_q : count_q + PW_W'(1);
      phase_d = '0;
    end else if (state_q == S_HIGH || state_q == S_LOW || state_q == S_DONE) begin
      phase_d = phase_q + CNT_W'(1);
    end

    // Jitter is taken after this cycle's advance (matters when W == 1).
    jit_c     = TW'(lfsr_d[7:0] & jmask_q);
    low_len_c = TW'(period_q) - TW'(width_q) + jit_c;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          period_d  = period;
          width_d   = pulse_width;
          npulses_d = num_pulses;
          jmask_d   = jitter_mask;
          if (cfg_bad_c) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d = 1'b0;
            count_d   = '0;
            lfsr_d    = LFSR_SEED;
            if (epoch == '0) begin
              state_d = S_HIGH;
              cnt_d   = TW'(pulse_width) - TW'(1);
            end else begin
              state_d = S_WAIT_EPOCH;
              cnt_d   = TW'(epoch) - TW'(1);
            end
          end
        end
      end
      S_WAIT_EPOCH: begin
        if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = TW'(width_q) - TW'(1);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          if (npulses_q != '0 && count_d == npulses_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOW;
            cnt_d   = low_len_c - TW'(1);
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = TW'(width_q) - TW'(1);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      width_q     <= '0;
      npulses_q   <= '0;
      jmask_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      cfg_err_q   <= 1'b0;
      count_q     <= '0;
      phase_q     <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      width_q     <= width_d;
      npulses_q   <= npulses_d;
      jmask_q     <= jmask_d;
      lfsr_q      <= lfsr_d;
      cfg_err_q   <= cfg_err_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: timing, config errors, jitter, stop,
// ignored restart and mid-run reset, with hand-derived expectations.
module tb_pulse_train_generator;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [31:0] period, epoch;
  logic [15:0] pulse_width, num_pulses;
  logic [7:0]  jitter_mask;
  logic        pulse_out, busy, done, cfg_err;
  logic [15:0] pulse_count;
  logic [31:0] phase_cnt;

  int tests  = 0;
  int failed = 0;
  int sp[2][9];
  int nrise;

  pulse_train_generator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .epoch      (epoch),
    .pulse_width(pulse_width),
    .num_pulses (num_pulses),
    .jitter_mask(jitter_mask),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .pulse_count(pulse_count),
    .phase_cnt  (phase_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive config with start for one edge; afterwards the bench sits in cycle 0.
  task automatic launch(input int p, input int e, input int w, input int n, input int j);
    period      = 32'(p);
    epoch       = 32'(e);
    pulse_width = 16'(w);
    num_pulses  = 16'(n);
    jitter_mask = 8'(j);
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // P=10 E=3 W=2 N=4: rises at 4,14,24,34; done at 36; busy drops at 37.
  task automatic run_p10();
    logic exp_po;
    launch(10, 3, 2, 4, 0);
    chk("p10_busy_c0", 64'(busy), 64'd0);
    for (int t = 1; t <= 40; t++) begin
      step();
      exp_po = (t >= 4 && t <= 35 && ((t - 4) % 10) < 2);
      chk($sformatf("p10_pulse_c%0d", t), 64'(pulse_out), 64'(exp_po));
      chk($sformatf("p10_done_c%0d", t), 64'(done), 64'(t == 36));
      if (t == 1)  chk("p10_busy_c1", 64'(busy), 64'd1);
      if (t == 4)  chk("p10_count_c4", 64'(pulse_count), 64'd1);
      if (t == 4)  chk("p10_phase_c4", 64'(phase_cnt), 64'd0);
      if (t == 13) chk("p10_phase_c13", 64'(phase_cnt), 64'd9);
      if (t == 36) chk("p10_count_c36", 64'(pulse_count), 64'd4);
      if (t == 36) chk("p10_busy_c36", 64'(busy), 64'd1);
      if (t == 37) chk("p10_busy_c37", 64'(busy), 64'd0);
    end
  endtask

  // Collect 9 rise-to-rise spacings of the jittered P=8 W=1 run into sp[r].
  task automatic collect(input int r);
    logic prev;
    int   last;
    prev  = 1'b0;
    last  = 0;
    nrise = 0;
    launch(8, 0, 1, 0, 7);
    for (int t = 1; t <= 200 && nrise < 10; t++) begin
      step();
      if (pulse_out && !prev) begin
        if (nrise == 0) chk($sformatf("jit%0d_first_rise", r), 64'(t), 64'd1);
        else sp[r][nrise-1] = t - last;
        last = t;
        nrise++;
      end
      prev = pulse_out;
    end
    chk($sformatf("jit%0d_rises", r), 64'(nrise), 64'd10);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk($sformatf("jit%0d_stop_busy", r), 64'(busy), 64'd0);
  endtask

  initial begin
    logic [15:0] l;
    logic        exp_po;
    int          rises;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    period = '0; epoch = '0; pulse_width = '0; num_pulses = '0; jitter_mask = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_pulse", 64'(pulse_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_count", 64'(pulse_count), 64'd0);
    chk("rst_phase", 64'(phase_cnt), 64'd0);

    // Basic timed run.
    run_p10();

    // Invalid W >= P, then a valid start clears the flag.
    launch(5, 0, 5, 1, 0);
    chk("cfg_err_set", 64'(cfg_err), 64'd1);
    for (int t = 1; t <= 5; t++) begin
      step();
      chk("cfg_busy_idle", 64'(busy), 64'd0);
      chk("cfg_pulse_idle", 64'(pulse_out), 64'd0);
    end
    launch(5, 0, 1, 1, 0);
    chk("cfg_err_clear", 64'(cfg_err), 64'd0);
    step();
    chk("cfg_ok_pulse", 64'(pulse_out), 64'd1);
    chk("cfg_ok_count", 64'(pulse_count), 64'd1);
    step();
    chk("cfg_ok_done", 64'(done), 64'd1);
    repeat (3) step();
    chk("cfg_ok_idle", 64'(busy), 64'd0);

    // Jittered run, twice, against the reference LFSR.
    collect(0);
    collect(1);
    l = 16'hACE1;
    for (int k = 0; k < 9; k++) begin
      l = lfsr_adv(l);
      chk($sformatf("jit_model_%0d", k), 64'(sp[0][k]), 64'(8 + int'(l[2:0])));
      chk($sformatf("jit_range_%0d", k), 64'(sp[0][k] >= 8 && sp[0][k] <= 15), 64'd1);
      chk($sformatf("jit_repeat_%0d", k), 64'(sp[1][k]), 64'(sp[0][k]));
    end

    // Stop in the second HIGH cycle of the third pulse.
    launch(4, 0, 2, 0, 0);
    for (int t = 1; t <= 9; t++) step();
    chk("stop_pre_pulse", 64'(pulse_out), 64'd1);
    chk("stop_pre_count", 64'(pulse_count), 64'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_pulse", 64'(pulse_out), 64'd0);
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_count", 64'(pulse_count), 64'd3);
    for (int t = 0; t < 10; t++) begin
      step();
      chk("stop_no_done", 64'(done), 64'd0);
      chk("stop_quiet", 64'(pulse_out), 64'd0);
    end
    chk("stop_count_hold", 64'(pulse_count), 64'd3);
    chk("stop_phase_hold", 64'(phase_cnt), 64'd1);

    // Start re-pulsed during pulse 2 must be ignored.
    launch(6, 0, 2, 3, 0);
    rises  = 0;
    exp_po = 1'b0;
    for (int t = 1; t <= 25; t++) begin
      step();
      start = 1'b0;
      if (pulse_out && !exp_po && (t == 1 || t == 7 || t == 13)) rises++;
      exp_po = (t == 1 || t == 2 || t == 7 || t == 8 || t == 13 || t == 14);
      chk($sformatf("rs_pulse_c%0d", t), 64'(pulse_out), 64'(exp_po));
      chk($sformatf("rs_done_c%0d", t), 64'(done), 64'(t == 15));
      if (t == 16) chk("rs_busy_c16", 64'(busy), 64'd0);
      if (t == 7) begin
        period      = 32'd3;
        pulse_width = 16'd1;
        num_pulses  = 16'd9;
        start       = 1'b1;
      end
    end
    chk("rs_rises", 64'(rises), 64'd3);
    chk("rs_count", 64'(pulse_count), 64'd3);

    // Reset during LOW, then a fresh run must match the first one.
    launch(10, 3, 2, 4, 0);
    for (int t = 1; t <= 8; t++) step();
    chk("rl_pre_count", 64'(pulse_count), 64'd1);
    chk("rl_pre_phase", 64'(phase_cnt), 64'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rl_pulse", 64'(pulse_out), 64'd0);
    chk("rl_busy", 64'(busy), 64'd0);
    chk("rl_done", 64'(done), 64'd0);
    chk("rl_cfg_err", 64'(cfg_err), 64'd0);
    chk("rl_count", 64'(pulse_count), 64'd0);
    chk("rl_phase", 64'(phase_cnt), 64'd0);
    step();
    run_p10();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
